// File: rtl/toy_mem_responder.sv
// Shared-array memory responder: read-only instruction port plus read/write data port, fixed RD_LAT read latency.
// Define TOY_MEM_ERRCNT_EN to build the saturating out-of-range counter on ERRCNT.

module toy_mem_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req,
  input  logic [31:0] rdata,
  output logic        vld,
  output logic [31:0] data
);
  logic [RD_LAT-1:0]       vld_pipe;
  logic [RD_LAT-1:0][31:0] dat_pipe;

  // Data stages load only behind a valid bit, so the last stage holds the previous response.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= req;
      if (req) dat_pipe[0] <= rdata;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign vld  = vld_pipe[RD_LAT-1];
  assign data = dat_pipe[RD_LAT-1];
endmodule

module toy_mem_responder #(
  parameter int AW         = 30,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LAT     = 1   // legal 1..4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IREQ,
  input  logic [AW-1:0] IADDR,
  output logic [31:0]   INSTR,
  output logic          IVALID,
  input  logic          DREQ,
  input  logic          DRW,
  input  logic [AW-1:0] DADDR,
  input  logic [31:0]   DWDATA,
  output logic [31:0]   DRDATA,
  output logic          DVALID,
  output logic          ERR,
  output logic [7:0]    ERRCNT
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] mem [DEPTH];

  logic                  irng, drng, iorr, dorr, d_we, d_rd;
  logic [DEPTH_LOG2-1:0] iidx, didx;
  logic [31:0]           irdata, drdata_raw;

  assign irng = (IADDR[AW-1:DEPTH_LOG2] == '0);
  assign drng = (DADDR[AW-1:DEPTH_LOG2] == '0);
  assign iidx = IADDR[DEPTH_LOG2-1:0];
  assign didx = DADDR[DEPTH_LOG2-1:0];
  assign iorr = IREQ & ~irng;
  assign dorr = DREQ & ~drng;
  assign d_we = DREQ & DRW & drng;
  assign d_rd = DREQ & ~DRW;

  // Reads sample the array before this edge's write lands, giving read-before-write.
  assign irdata     = irng ? mem[iidx] : 32'h0;
  assign drdata_raw = drng ? mem[didx] : 32'h0;

  // Array is deliberately outside the reset domain.
  always_ff @(posedge CLK) begin
    if (d_we) mem[didx] <= DWDATA;
  end

  toy_mem_pipe #(.RD_LAT(RD_LAT)) u_ipipe (
    .CLK(CLK), .RST(RST), .req(IREQ), .rdata(irdata), .vld(IVALID), .data(INSTR)
  );

  toy_mem_pipe #(.RD_LAT(RD_LAT)) u_dpipe (
    .CLK(CLK), .RST(RST), .req(d_rd), .rdata(drdata_raw), .vld(DVALID), .data(DRDATA)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)              ERR <= 1'b0;
    else if (iorr | dorr) ERR <= 1'b1;
  end

`ifdef TOY_MEM_ERRCNT_EN
  logic [7:0] errcnt;
  logic [8:0] cnt_sum;

  assign cnt_sum = {1'b0, errcnt} + {8'b0, iorr} + {8'b0, dorr};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) errcnt <= '0;
    else     errcnt <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  assign ERRCNT = errcnt;
`else
  assign ERRCNT = 8'h0;
`endif
endmodule

// File: tb/tb_toy_mem_responder.sv
// Directed bench: three responders (RD_LAT 1,2,3) share one stimulus stream; index k has RD_LAT k+1.
`timescale 1ns/1ps
module tb_toy_mem_responder;
  localparam int AW = 30;
`ifdef TOY_MEM_ERRCNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic          CLK, RST;
  logic          IREQ, DREQ, DRW;
  logic [AW-1:0] IADDR, DADDR;
  logic [31:0]   DWDATA;
  logic [2:0][31:0] instr, drdata;
  logic [2:0]       ivalid, dvalid, err;
  logic [2:0][7:0]  errcnt;

  int total = 0;
  int bad   = 0;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    toy_mem_responder #(.AW(AW), .DEPTH_LOG2(10), .RD_LAT(k+1)) u_dut (
      .CLK(CLK), .RST(RST),
      .IREQ(IREQ), .IADDR(IADDR), .INSTR(instr[k]), .IVALID(ivalid[k]),
      .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA),
      .DRDATA(drdata[k]), .DVALID(dvalid[k]),
      .ERR(err[k]), .ERRCNT(errcnt[k])
    );
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    DREQ = 1'b1; DRW = 1'b1; DADDR = a; DWDATA = d;
    tick();
    DREQ = 1'b0; DRW = 1'b0;
  endtask

  initial begin
    RST = 1'b1; IREQ = 1'b0; DREQ = 1'b0; DRW = 1'b0;
    IADDR = '0; DADDR = '0; DWDATA = '0;
    idle(2);
    for (int k = 0; k < 3; k++) begin
      chk("rst_ivalid", 32'(ivalid[k]), 32'h0);
      chk("rst_dvalid", 32'(dvalid[k]), 32'h0);
      chk("rst_instr",  instr[k],       32'h0);
      chk("rst_drdata", drdata[k],      32'h0);
      chk("rst_err",    32'(err[k]),    32'h0);
      chk("rst_errcnt", 32'(errcnt[k]), 32'h0);
    end
    RST = 1'b0;
    tick();

    wr(30'd0, 32'h10); wr(30'd1, 32'h11); wr(30'd2, 32'h12); wr(30'd7, 32'hAA);
    idle(3);

    // write then read-back on the data port
    wr(30'd5, 32'hDEADBEEF);
    DREQ = 1'b1; DRW = 1'b0; DADDR = 30'd5;
    tick();
    DREQ = 1'b0;
    chk("l1_dvalid", 32'(dvalid[0]), 32'h1);
    chk("l1_drdata", drdata[0], 32'hDEADBEEF);
    chk("l2_dvalid_early", 32'(dvalid[1]), 32'h0);
    tick();
    chk("l1_dvalid_once", 32'(dvalid[0]), 32'h0);
    chk("l1_drdata_hold", drdata[0], 32'hDEADBEEF);
    chk("l2_dvalid", 32'(dvalid[1]), 32'h1);
    chk("l2_drdata", drdata[1], 32'hDEADBEEF);
    tick();
    chk("l3_dvalid", 32'(dvalid[2]), 32'h1);
    idle(4);

    // back-to-back instruction fetches
    IREQ = 1'b1; IADDR = 30'd0;
    tick();
    chk("l1_i0_valid", 32'(ivalid[0]), 32'h1);
    chk("l1_i0", instr[0], 32'h10);
    chk("l3_i_early0", 32'(ivalid[2]), 32'h0);
    IADDR = 30'd1;
    tick();
    chk("l3_i_early1", 32'(ivalid[2]), 32'h0);
    IADDR = 30'd2;
    tick();
    IREQ = 1'b0;
    chk("l3_i0_valid", 32'(ivalid[2]), 32'h1);
    chk("l3_i0", instr[2], 32'h10);
    tick();
    chk("l3_i1_valid", 32'(ivalid[2]), 32'h1);
    chk("l3_i1", instr[2], 32'h11);
    tick();
    chk("l3_i2_valid", 32'(ivalid[2]), 32'h1);
    chk("l3_i2", instr[2], 32'h12);
    tick();
    chk("l3_i_done", 32'(ivalid[2]), 32'h0);
    chk("l3_i_hold", instr[2], 32'h12);
    idle(4);

    // same-cycle write and fetch of one word
    DREQ = 1'b1; DRW = 1'b1; DADDR = 30'd7; DWDATA = 32'h55;
    IREQ = 1'b1; IADDR = 30'd7;
    tick();
    DREQ = 1'b0; DRW = 1'b0;
    chk("rbw_old", instr[0], 32'hAA);
    tick();
    IREQ = 1'b0;
    chk("rbw_new_valid", 32'(ivalid[0]), 32'h1);
    chk("rbw_new", instr[0], 32'h55);
    chk("err_clean", 32'(err[0]), 32'h0);
    idle(4);

    // out-of-range on both ports in one cycle
    IREQ = 1'b1; IADDR = 30'h800;
    DREQ = 1'b1; DRW = 1'b0; DADDR = 30'h400;
    tick();
    chk("oor_dvalid", 32'(dvalid[0]), 32'h1);
    chk("oor_drdata", drdata[0], 32'h0);
    chk("oor_ivalid", 32'(ivalid[0]), 32'h1);
    chk("oor_instr", instr[0], 32'h0);
    chk("oor_err", 32'(err[0]), 32'h1);
    chk("oor_errcnt2", 32'(errcnt[0]), CNT_ON ? 32'd2 : 32'd0);
    IREQ = 1'b0; DRW = 1'b1; DWDATA = 32'hFFFFFFFF;
    tick();
    DREQ = 1'b0; DRW = 1'b0;
    IREQ = 1'b1; IADDR = 30'd0;
    tick();
    IREQ = 1'b0;
    chk("oor_wr_dropped", instr[0], 32'h10);
    chk("oor_errcnt3", 32'(errcnt[0]), CNT_ON ? 32'd3 : 32'd0);
    idle(3);
    chk("err_sticky", 32'(err[0]), 32'h1);

    // counter saturation
    IREQ = 1'b1; IADDR = 30'h800;
    idle(260);
    IREQ = 1'b0;
    tick();
    chk("errcnt_sat_l1", 32'(errcnt[0]), CNT_ON ? 32'd255 : 32'd0);
    chk("errcnt_sat_l3", 32'(errcnt[2]), CNT_ON ? 32'd255 : 32'd0);
    idle(4);

    // reset with reads in flight (RD_LAT=2 instance)
    IREQ = 1'b1; IADDR = 30'd1;
    DREQ = 1'b1; DRW = 1'b0; DADDR = 30'd2;
    tick();
    IREQ = 1'b0; DREQ = 1'b0;
    RST = 1'b1;
    #1;
    chk("mrst_ivalid", 32'(ivalid[1]), 32'h0);
    chk("mrst_dvalid", 32'(dvalid[1]), 32'h0);
    chk("mrst_instr", instr[1], 32'h0);
    chk("mrst_drdata", drdata[1], 32'h0);
    chk("mrst_err", 32'(err[1]), 32'h0);
    chk("mrst_errcnt", 32'(errcnt[1]), 32'h0);
    tick();
    chk("mrst_no_ivalid", 32'(ivalid[1]), 32'h0);
    chk("mrst_no_dvalid", 32'(dvalid[1]), 32'h0);
    RST = 1'b0;
    tick();
    IREQ = 1'b1; IADDR = 30'd2;
    DREQ = 1'b1; DRW = 1'b0; DADDR = 30'd5;
    tick();
    IREQ = 1'b0; DREQ = 1'b0;
    chk("post_rst_early", 32'(ivalid[1]), 32'h0);
    tick();
    chk("post_rst_ivalid", 32'(ivalid[1]), 32'h1);
    chk("post_rst_instr", instr[1], 32'h12);
    chk("post_rst_dvalid", 32'(dvalid[1]), 32'h1);
    chk("post_rst_drdata", drdata[1], 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
